// File: rtl/fxy_sweep_ctrl.sv
// Truth-table sweep controller: walks every input vector of an N-input function
// block, holds each for SETTLE cycles, captures its output, and optionally
// compares the table against EXP (enabled by defining FXY_SWEEP_CHECK_EN).
module fxy_sweep_ctrl #(
    parameter int unsigned N      = 2,
    parameter int unsigned SETTLE = 1,
    parameter logic [(2**N)-1:0] EXP = 4'b0001
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                abort,
    input  logic                s_in,
    output logic [N-1:0]        vec_out,
    output logic [(2**N)-1:0]   tt_out,
    output logic                busy,
    output logic                done,
    output logic                err
);

    localparam int unsigned VEC_W = N;
    localparam int unsigned TT_W  = 2**N;
    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WAIT    = 2'd1,
        S_CAPTURE = 2'd2,
        S_DONE    = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [VEC_W-1:0]   vec_q,   vec_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;
    logic [TT_W-1:0]    tt_q,    tt_d;
    logic               busy_q,  busy_d;
    logic               done_q,  done_d;
`ifdef FXY_SWEEP_CHECK_EN
    logic               err_q,   err_d;
`endif

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            vec_q   <= '0;
            cnt_q   <= '0;
            tt_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef FXY_SWEEP_CHECK_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            cnt_q   <= cnt_d;
            tt_q    <= tt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef FXY_SWEEP_CHECK_EN
            err_q   <= err_d;
`endif
        end
    end

    // Next-state logic; busy/done are derived from the next state so they stay registered
    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        cnt_d   = cnt_q;
        tt_d    = tt_q;
`ifdef FXY_SWEEP_CHECK_EN
        err_d   = err_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    state_d = S_WAIT;
                    vec_d   = '0;
                    cnt_d   = '0;
                    tt_d    = '0;
`ifdef FXY_SWEEP_CHECK_EN
                    err_d   = 1'b0;
`endif
                end
            end
            S_WAIT: begin
                if (abort) begin
                    state_d = S_IDLE;
                    vec_d   = '0;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(SETTLE - 1)) begin
                        state_d = S_CAPTURE;
                    end
                end
            end
            S_CAPTURE: begin
                if (abort) begin
                    state_d = S_IDLE;
                    vec_d   = '0;
                    cnt_d   = '0;
                end else begin
                    tt_d[vec_q] = s_in;
                    // Terminal vector always ends the sweep; the increment never wraps
                    if (vec_q == {VEC_W{1'b1}}) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_WAIT;
                        vec_d   = vec_q + VEC_W'(1);
                        cnt_d   = '0;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                vec_d   = '0;
`ifdef FXY_SWEEP_CHECK_EN
                err_d   = (tt_q != EXP);
`endif
            end
            default: begin
                state_d = S_IDLE;
                vec_d   = '0;
                cnt_d   = '0;
            end
        endcase

        busy_d = (state_d == S_WAIT) || (state_d == S_CAPTURE);
        done_d = (state_d == S_DONE);
    end

    assign vec_out = vec_q;
    assign tt_out  = tt_q;
    assign busy    = busy_q;
    assign done    = done_q;

`ifdef FXY_SWEEP_CHECK_EN
    assign err = err_q;
`else
    // No comparator in this build; EXP is kept only so the parameter list is unchanged
    logic unused_exp_c;
    assign unused_exp_c = ^EXP;
    assign err = 1'b0;
`endif

endmodule
